ysyx_22040750_axi_rd_arbiter: RTL and testbench
===============================================

// Module: ysyx_22040750_axi_rd_arbiter
// PURPOSE
//  Two-requester AXI4 read-channel arbiter between the icache refill port (m0) and the dcache refill port (m1).
//  Output is a single AXI4 master read port toward io_master_ar*/r*.
//  Grants one burst at a time, round-robin, and holds the grant until the rlast beat completes.
//  Routes R beats back to the granted requester only and checks burst length against arlen.
// PARAMETERS
//  ADDR_W  32  address width
//  DATA_W  64  R data width
//  ID_W    4   arid width
//  M0_ID   0   arid driven for m0 bursts
//  M1_ID   1   arid driven for m1 bursts
// PORTS
//  I_clk             in   1       clock
//  I_rst             in   1       reset, asynchronous, active-high
//  I_m{0,1}_arvalid  in   1       requester read request
//  O_m{0,1}_arready  out  1       one-cycle request-accept pulse
//  I_m{0,1}_araddr   in   ADDR_W  burst start address
//  I_m{0,1}_arlen    in   8       beats-1
//  I_m{0,1}_arsize   in   3       beat size
//  O_m{0,1}_rdata    out  DATA_W  returned beat
//  O_m{0,1}_rvalid   out  1       beat valid to this requester
//  I_m{0,1}_rready   in   1       requester accepts beat
//  O_m{0,1}_rlast    out  1       last beat of burst
//  O_axi_arvalid/I_axi_arready  out/in  1  AR handshake
//  O_axi_araddr      out  ADDR_W  registered address
//  O_axi_arlen/_arsize  out  8/3  registered len/size
//  O_axi_arid        out  ID_W    M0_ID or M1_ID
//  O_axi_arburst     out  2       constant 2'b01 (INCR)
//  I_axi_rvalid/O_axi_rready  in/out  1  R handshake
//  I_axi_rdata       in   DATA_W  R data
//  I_axi_rlast       in   1       R last
//  I_axi_rresp       in   2       R response
//  O_err             out  1       sticky protocol/response error
// BEHAVIOUR
//  - Reset (async): state=IDLE; all outputs 0 except arburst=2'b01; priority pointer favours m0; beat counter 0; O_err 0.
//  - FSM IDLE -> ADDR -> DATA -> IDLE.
//  - IDLE: if any arvalid, grant one requester and pulse its arready for 1 cycle.
//    Latch addr/len/size/id into AR registers and go to ADDR.
//    Both requesting: grant the one not granted last; first-ever tie goes to m0.
//  - ADDR: O_axi_arvalid=1 with stable fields until I_axi_arready.
//    On handshake, deassert arvalid next cycle, clear beat counter, go to DATA.
//    Minimum IDLE-to-arvalid latency is 1 cycle.
//  - DATA: R path is combinational.
//    Granted requester: rvalid = I_axi_rvalid, rdata = I_axi_rdata, rlast = I_axi_rlast.
//    O_axi_rready = granted requester's rready.
//    Non-granted requester sees rvalid=0 and rlast=0.
//    Counter increments on each rvalid&rready beat.
//    A beat with rlast, or the beat where counter==arlen, ends the burst: go to IDLE next cycle.
//  - Length check sets O_err if rlast arrives with counter!=arlen, or counter==arlen arrives without rlast.
//    Either case still terminates the burst.
//  - Any beat with rresp!=2'b00 sets O_err; the beat is still forwarded.
//  - O_err clears only on reset.
//  - Outside IDLE: arready stays 0 for both requesters; their arvalid is held by AXI rules and no request is lost.
//  - Back-to-back: a new grant can occur in the IDLE cycle after the last beat, giving 1 idle cycle between bursts.
//  - Priority pointer updates at grant time, not at burst end.
//  - R beats while in IDLE/ADDR are not accepted: O_axi_rready=0.
//  - arlen=0: single-beat burst; the first beat ends DATA.
//  - Reset mid-burst aborts immediately with no completion signalled; the slave must also be reset.
// TESTING
//  - m0 alone, araddr=0x8000_0000, arlen=1:
//    arvalid 1 cycle later, arid=0, arburst=01; 2 beats to m0 with rlast on beat 2; m1 sees no rvalid; back to IDLE.
//  - m0 and m1 both request from reset:
//    m0 granted first; m1 granted in the IDLE cycle after m0's rlast; then a second tie grants m0 again.
//  - I_axi_arready held low 5 cycles:
//    arvalid/araddr/arlen stable all 5 cycles; no arready pulse to either requester during ADDR.
//  - Granted requester drops rready for 3 cycles mid-burst:
//    O_axi_rready=0 for those cycles; beat count unchanged; data delivered in order.
//  - arlen=3 but slave asserts rlast on beat 2:
//    burst ends; O_err=1 and stays 1 until reset; next request is still served.
//  - rresp=2'b10 on beat 1:
//    O_err=1, data forwarded; async reset mid-DATA drops all outputs to 0 that cycle and clears O_err.

Source files
------------

// File: rtl/ysyx_22040750_axi_rd_arbiter.sv
// Two-requester AXI4 read arbiter: icache (m0) and dcache (m1) share one AXI master read port.
// Round-robin grant per burst, held until the burst ends; the R path is routed combinationally to the owner.
module ysyx_22040750_axi_rd_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64,
   parameter int ID_W   = 4,
   parameter int M0_ID  = 0,
   parameter int M1_ID  = 1
) (
   input  logic              I_clk,
   input  logic              I_rst,
   // requester 0 (icache refill)
   input  logic              I_m0_arvalid,
   output logic              O_m0_arready,
   input  logic [ADDR_W-1:0] I_m0_araddr,
   input  logic [7:0]        I_m0_arlen,
   input  logic [2:0]        I_m0_arsize,
   output logic [DATA_W-1:0] O_m0_rdata,
   output logic              O_m0_rvalid,
   input  logic              I_m0_rready,
   output logic              O_m0_rlast,
   // requester 1 (dcache refill)
   input  logic              I_m1_arvalid,
   output logic              O_m1_arready,
   input  logic [ADDR_W-1:0] I_m1_araddr,
   input  logic [7:0]        I_m1_arlen,
   input  logic [2:0]        I_m1_arsize,
   output logic [DATA_W-1:0] O_m1_rdata,
   output logic              O_m1_rvalid,
   input  logic              I_m1_rready,
   output logic              O_m1_rlast,
   // shared AXI read master
   output logic              O_axi_arvalid,
   input  logic              I_axi_arready,
   output logic [ADDR_W-1:0] O_axi_araddr,
   output logic [7:0]        O_axi_arlen,
   output logic [2:0]        O_axi_arsize,
   output logic [ID_W-1:0]   O_axi_arid,
   output logic [1:0]        O_axi_arburst,
   input  logic              I_axi_rvalid,
   output logic              O_axi_rready,
   input  logic [DATA_W-1:0] I_axi_rdata,
   input  logic              I_axi_rlast,
   input  logic [1:0]        I_axi_rresp,
   output logic              O_err
);

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

   state_t              r_state;
   logic                r_prio_m0;
   logic                r_gnt_m1;
   logic                r_arvalid;
   logic                r_err;
   logic [ADDR_W-1:0]   r_araddr;
   logic [7:0]          r_arlen;
   logic [2:0]          r_arsize;
   logic [ID_W-1:0]     r_arid;
   logic [7:0]          r_cnt;

   logic w_idle, w_data;
   logic w_gnt0, w_gnt1;
   logic w_rready, w_beat, w_cnt_hit;
   logic w_own0, w_own1;

   assign w_idle    = (r_state == S_IDLE);
   assign w_data    = (r_state == S_DATA);
   // On a tie the pointer picks whoever was not granted last.
   assign w_gnt0    = w_idle & I_m0_arvalid & (~I_m1_arvalid | r_prio_m0);
   assign w_gnt1    = w_idle & I_m1_arvalid & ~w_gnt0;
   assign w_own0    = w_data & ~r_gnt_m1;
   assign w_own1    = w_data &  r_gnt_m1;
   assign w_rready  = (w_own0 & I_m0_rready) | (w_own1 & I_m1_rready);
   assign w_beat    = I_axi_rvalid & w_rready;
   assign w_cnt_hit = (r_cnt == r_arlen);

   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         r_state   <= S_IDLE;
         r_prio_m0 <= 1'b1;
         r_gnt_m1  <= 1'b0;
         r_arvalid <= 1'b0;
         r_err     <= 1'b0;
         r_araddr  <= '0;
         r_arlen   <= '0;
         r_arsize  <= '0;
         r_arid    <= '0;
         r_cnt     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_gnt0) begin
                  r_araddr  <= I_m0_araddr;
                  r_arlen   <= I_m0_arlen;
                  r_arsize  <= I_m0_arsize;
                  r_arid    <= ID_W'(M0_ID);
                  r_gnt_m1  <= 1'b0;
                  r_prio_m0 <= 1'b0;
                  r_arvalid <= 1'b1;
                  r_state   <= S_ADDR;
               end else if (w_gnt1) begin
                  r_araddr  <= I_m1_araddr;
                  r_arlen   <= I_m1_arlen;
                  r_arsize  <= I_m1_arsize;
                  r_arid    <= ID_W'(M1_ID);
                  r_gnt_m1  <= 1'b1;
                  r_prio_m0 <= 1'b1;
                  r_arvalid <= 1'b1;
                  r_state   <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (I_axi_arready) begin
                  r_arvalid <= 1'b0;
                  r_cnt     <= '0;
                  r_state   <= S_DATA;
               end
            end
            S_DATA: begin
               if (w_beat) begin
                  r_cnt <= r_cnt + 8'd1;
                  // rlast must coincide with the arlen-th beat; a bad response is flagged but forwarded
                  if ((I_axi_rlast != w_cnt_hit) || (I_axi_rresp != 2'b00))
                     r_err <= 1'b1;
                  if (I_axi_rlast || w_cnt_hit)
                     r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign O_m0_arready  = w_gnt0;
   assign O_m1_arready  = w_gnt1;

   assign O_axi_arvalid = r_arvalid;
   assign O_axi_araddr  = r_araddr;
   assign O_axi_arlen   = r_arlen;
   assign O_axi_arsize  = r_arsize;
   assign O_axi_arid    = r_arid;
   assign O_axi_arburst = 2'b01;
   assign O_axi_rready  = w_rready;
   assign O_err         = r_err;

   assign O_m0_rvalid   = w_own0 & I_axi_rvalid;
   assign O_m0_rlast    = w_own0 & I_axi_rlast;
   assign O_m0_rdata    = w_own0 ? I_axi_rdata : '0;
   assign O_m1_rvalid   = w_own1 & I_axi_rvalid;
   assign O_m1_rlast    = w_own1 & I_axi_rlast;
   assign O_m1_rdata    = w_own1 ? I_axi_rdata : '0;

endmodule

// File: tb/tb_ysyx_22040750_axi_rd_arbiter.sv
// Directed bench for the two-requester AXI read arbiter.
// Inputs change 1ns after the rising edge; outputs are checked 1ns later.
module tb_ysyx_22040750_axi_rd_arbiter;

   logic        I_clk = 1'b0;
   logic        I_rst;
   logic        I_m0_arvalid, I_m1_arvalid;
   logic        O_m0_arready, O_m1_arready;
   logic [31:0] I_m0_araddr, I_m1_araddr;
   logic [7:0]  I_m0_arlen, I_m1_arlen;
   logic [2:0]  I_m0_arsize, I_m1_arsize;
   logic [63:0] O_m0_rdata, O_m1_rdata;
   logic        O_m0_rvalid, O_m1_rvalid;
   logic        I_m0_rready, I_m1_rready;
   logic        O_m0_rlast, O_m1_rlast;
   logic        O_axi_arvalid, I_axi_arready;
   logic [31:0] O_axi_araddr;
   logic [7:0]  O_axi_arlen;
   logic [2:0]  O_axi_arsize;
   logic [3:0]  O_axi_arid;
   logic [1:0]  O_axi_arburst;
   logic        I_axi_rvalid, O_axi_rready;
   logic [63:0] I_axi_rdata;
   logic        I_axi_rlast;
   logic [1:0]  I_axi_rresp;
   logic        O_err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 I_clk = ~I_clk;

   ysyx_22040750_axi_rd_arbiter dut (
      .I_clk(I_clk), .I_rst(I_rst),
      .I_m0_arvalid(I_m0_arvalid), .O_m0_arready(O_m0_arready), .I_m0_araddr(I_m0_araddr),
      .I_m0_arlen(I_m0_arlen), .I_m0_arsize(I_m0_arsize), .O_m0_rdata(O_m0_rdata),
      .O_m0_rvalid(O_m0_rvalid), .I_m0_rready(I_m0_rready), .O_m0_rlast(O_m0_rlast),
      .I_m1_arvalid(I_m1_arvalid), .O_m1_arready(O_m1_arready), .I_m1_araddr(I_m1_araddr),
      .I_m1_arlen(I_m1_arlen), .I_m1_arsize(I_m1_arsize), .O_m1_rdata(O_m1_rdata),
      .O_m1_rvalid(O_m1_rvalid), .I_m1_rready(I_m1_rready), .O_m1_rlast(O_m1_rlast),
      .O_axi_arvalid(O_axi_arvalid), .I_axi_arready(I_axi_arready), .O_axi_araddr(O_axi_araddr),
      .O_axi_arlen(O_axi_arlen), .O_axi_arsize(O_axi_arsize), .O_axi_arid(O_axi_arid),
      .O_axi_arburst(O_axi_arburst), .I_axi_rvalid(I_axi_rvalid), .O_axi_rready(O_axi_rready),
      .I_axi_rdata(I_axi_rdata), .I_axi_rlast(I_axi_rlast), .I_axi_rresp(I_axi_rresp),
      .O_err(O_err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge I_clk);
      #1;
   endtask

   task automatic clear_inputs();
      I_m0_arvalid = 0; I_m0_araddr = 0; I_m0_arlen = 0; I_m0_arsize = 0; I_m0_rready = 0;
      I_m1_arvalid = 0; I_m1_araddr = 0; I_m1_arlen = 0; I_m1_arsize = 0; I_m1_rready = 0;
      I_axi_arready = 0; I_axi_rvalid = 0; I_axi_rdata = 0; I_axi_rlast = 0; I_axi_rresp = 0;
   endtask

   task automatic do_reset();
      I_rst = 1;
      clear_inputs();
      tick();
      tick();
      chk("rst_arvalid", O_axi_arvalid, 0);
      chk("rst_arburst", O_axi_arburst, 2'b01);
      chk("rst_err", O_err, 0);
      chk("rst_araddr", O_axi_araddr, 0);
      chk("rst_arid", O_axi_arid, 0);
      chk("rst_rready", O_axi_rready, 0);
      chk("rst_m0_rdata", O_m0_rdata, 0);
      I_rst = 0;
      tick();
   endtask

   // Called in the first ADDR cycle; completes the AR handshake.
   task automatic addr_phase(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id);
      #1;
      chk("ar_valid", O_axi_arvalid, 1);
      chk("ar_addr", O_axi_araddr, a);
      chk("ar_len", O_axi_arlen, len);
      chk("ar_id", O_axi_arid, id);
      chk("ar_burst", O_axi_arburst, 2'b01);
      chk("ar_m0_ready_quiet", O_m0_arready, 0);
      chk("ar_m1_ready_quiet", O_m1_arready, 0);
      I_axi_arready = 1;
      tick();
      I_axi_arready = 0;
   endtask

   // One accepted beat toward the owner; checks routing to both requesters.
   task automatic beat(input bit to_m1, input logic [63:0] d, input bit last, input logic [1:0] resp);
      I_axi_rvalid = 1; I_axi_rdata = d; I_axi_rlast = last; I_axi_rresp = resp;
      #1;
      chk("r_rready", O_axi_rready, 1);
      chk("r_own_valid", to_m1 ? O_m1_rvalid : O_m0_rvalid, 1);
      chk("r_own_data", to_m1 ? O_m1_rdata : O_m0_rdata, d);
      chk("r_own_last", to_m1 ? O_m1_rlast : O_m0_rlast, last);
      chk("r_other_valid", to_m1 ? O_m0_rvalid : O_m1_rvalid, 0);
      chk("r_other_last", to_m1 ? O_m0_rlast : O_m1_rlast, 0);
      tick();
      I_axi_rvalid = 0; I_axi_rlast = 0; I_axi_rresp = 0;
   endtask

   initial begin
      clear_inputs();
      do_reset();

      // m0 alone, 2-beat burst
      I_m0_arvalid = 1; I_m0_araddr = 32'h8000_0000; I_m0_arlen = 1; I_m0_arsize = 3;
      #1;
      chk("t1_m0_arready", O_m0_arready, 1);
      chk("t1_m1_arready", O_m1_arready, 0);
      chk("t1_arvalid_not_yet", O_axi_arvalid, 0);
      tick();
      I_m0_arvalid = 0;
      chk("t1_arsize", O_axi_arsize, 3);
      addr_phase(32'h8000_0000, 1, 0);
      chk("t1_arvalid_dropped", O_axi_arvalid, 0);
      I_m0_rready = 1; I_m1_rready = 1;
      beat(0, 64'h1111_0000_0000_0001, 0, 0);
      beat(0, 64'h1111_0000_0000_0002, 1, 0);
      #1;
      chk("t1_idle_rready", O_axi_rready, 0);
      chk("t1_err", O_err, 0);
      tick();

      // tie from reset: m0, then m1, then m0 again
      do_reset();
      I_m0_rready = 1; I_m1_rready = 1;
      I_m0_arvalid = 1; I_m0_araddr = 32'h1000; I_m0_arlen = 0;
      I_m1_arvalid = 1; I_m1_araddr = 32'h2000; I_m1_arlen = 0;
      #1;
      chk("t2_tie1_m0", O_m0_arready, 1);
      chk("t2_tie1_m1", O_m1_arready, 0);
      tick();
      I_m0_arvalid = 0;
      addr_phase(32'h1000, 0, 0);
      beat(0, 64'hA0, 1, 0);
      #1;
      chk("t2_m1_grant", O_m1_arready, 1);
      chk("t2_m0_nogrant", O_m0_arready, 0);
      tick();
      I_m1_arvalid = 0;
      addr_phase(32'h2000, 0, 1);
      beat(1, 64'hB0, 1, 0);
      I_m0_arvalid = 1; I_m0_araddr = 32'h3000; I_m0_arlen = 2;
      I_m1_arvalid = 1; I_m1_araddr = 32'h4000; I_m1_arlen = 3;
      #1;
      chk("t2_tie2_m0", O_m0_arready, 1);
      chk("t2_tie2_m1", O_m1_arready, 0);
      tick();
      I_m0_arvalid = 0;

      // slave stalls AR for 5 cycles while m1 keeps requesting
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("t3_arvalid_%0d", i), O_axi_arvalid, 1);
         chk($sformatf("t3_araddr_%0d", i), O_axi_araddr, 32'h3000);
         chk($sformatf("t3_arlen_%0d", i), O_axi_arlen, 2);
         chk($sformatf("t3_m1_arready_%0d", i), O_m1_arready, 0);
         tick();
      end
      addr_phase(32'h3000, 2, 0);

      // m0 stalls R for 3 cycles mid-burst
      beat(0, 64'hC0, 0, 0);
      I_m0_rready = 0; I_axi_rvalid = 1; I_axi_rdata = 64'hC1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("t4_rready_low_%0d", i), O_axi_rready, 0);
         tick();
      end
      I_m0_rready = 1;
      beat(0, 64'hC1, 0, 0);
      beat(0, 64'hC2, 1, 0);
      #1;
      chk("t4_err_clean", O_err, 0);

      // m1 burst with arlen=3 but rlast on beat 2
      chk("t5_m1_grant", O_m1_arready, 1);
      tick();
      I_m1_arvalid = 0;
      addr_phase(32'h4000, 3, 1);
      beat(1, 64'hD0, 0, 0);
      beat(1, 64'hD1, 1, 0);
      I_m0_arvalid = 1; I_m0_araddr = 32'h5000; I_m0_arlen = 0;
      #1;
      chk("t5_err_short", O_err, 1);
      chk("t5_next_served", O_m0_arready, 1);
      tick();
      I_m0_arvalid = 0;
      addr_phase(32'h5000, 0, 0);
      beat(0, 64'hE0, 1, 0);
      #1;
      chk("t5_err_sticky", O_err, 1);

      // counter reaches arlen without rlast
      do_reset();
      I_m0_rready = 1; I_m1_rready = 1;
      I_m1_arvalid = 1; I_m1_araddr = 32'h6000; I_m1_arlen = 0;
      tick();
      I_m1_arvalid = 0;
      addr_phase(32'h6000, 0, 1);
      beat(1, 64'hF0, 0, 0);
      #1;
      chk("t5b_err_nolast", O_err, 1);
      chk("t5b_idle_rready", O_axi_rready, 0);

      // error response, then reset mid-DATA
      do_reset();
      I_m0_rready = 1;
      I_m0_arvalid = 1; I_m0_araddr = 32'h7000; I_m0_arlen = 1;
      tick();
      I_m0_arvalid = 0;
      addr_phase(32'h7000, 1, 0);
      beat(0, 64'h9999, 0, 2'b10);
      I_axi_rvalid = 1; I_axi_rdata = 64'h7777;
      #1;
      chk("t6_err_resp", O_err, 1);
      chk("t6_still_data", O_m0_rvalid, 1);
      I_rst = 1;
      #1;
      chk("t6_rst_rvalid", O_m0_rvalid, 0);
      chk("t6_rst_rdata", O_m0_rdata, 0);
      chk("t6_rst_rready", O_axi_rready, 0);
      chk("t6_rst_err", O_err, 0);
      chk("t6_rst_arburst", O_axi_arburst, 2'b01);
      clear_inputs();
      tick();
      I_rst = 0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
